rv_div_seq: RTL and testbench

Issue-side sequencer for the radix-4 SRT divider core `rv_div`, sitting between the execute stage and the core. It accepts RISC-V M-extension divide/remainder requests (DIV, DIVU, REM, REMU and the W forms) and resolves divide-by-zero, signed overflow and large-unsigned cases without the core. It drives the core's `vld_i`/`ready_o` handshake, applies post-correction and sign-extension, and returns a tagged 64-bit result over a valid/ready handshake.

---
 rtl/rv_div_seq.sv | 208 ++++++++++++++++++++
 tb/tb_rv_div_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_div_seq.sv
// Issue-side sequencer for the rv_div radix-4 SRT core: resolves divide special cases
// locally, splits large unsigned dividends, and post-corrects/sign-extends core results.
module rv_div_seq #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush_i,
    input  logic             req_vld_i,
    output logic             req_rdy_o,
    input  logic [2:0]       req_op_i,
    input  logic [63:0]      req_a_i,
    input  logic [63:0]      req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             rsp_vld_o,
    input  logic             rsp_rdy_i,
    output logic [63:0]      rsp_data_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_dz_o,
    output logic             div_vld_o,
    output logic [63:0]      div_op1_o,
    output logic [63:0]      div_op2_o,
    input  logic [63:0]      div_quo_i,
    input  logic [63:0]      div_rem_i,
    input  logic             div_ready_i
);

    typedef enum logic [2:0] {IDLE, PREP, ISSUE, WAIT, FIX, RESP, DRAIN} state_t;

    typedef struct packed {
        logic [2:0]       op;
        logic [63:0]      a;
        logic [63:0]      b;
        logic [TAG_W-1:0] tag;
    } req_t;

    state_t      state;
    req_t        req;
    logic        split;
    logic        seen_low;
    logic [63:0] quo_q;
    logic [63:0] rem_q;

    function automatic logic [63:0] sext32(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    logic        is_uns, is_rem, is_w;
    logic [63:0] wa, wb;
    logic        b_zero, ovf, big_b, need_split;

    assign is_uns = req.op[0];
    assign is_rem = req.op[1];
    assign is_w   = req.op[2];
    assign wa     = is_w ? (is_uns ? {32'b0, req.a[31:0]} : sext32(req.a)) : req.a;
    assign wb     = is_w ? (is_uns ? {32'b0, req.b[31:0]} : sext32(req.b)) : req.b;

    assign b_zero     = (wb == '0);
    assign ovf        = !is_uns && (wb == '1) &&
                        (wa == (is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    assign big_b      = !is_w && is_uns && wb[63];
    assign need_split = !is_w && is_uns && wa[63];

    // Results that never need the core; the overflow quotient is the operating-width MIN, i.e. wa.
    logic [63:0] sp_q, sp_r, sp_res;
    always_comb begin
        sp_q = '1;
        sp_r = wa;
        if (b_zero) begin
            sp_q = '1;
            sp_r = wa;
        end else if (ovf) begin
            sp_q = wa;
            sp_r = '0;
        end else if (wa >= wb) begin
            sp_q = 64'd1;
            sp_r = wa - wb;
        end else begin
            sp_q = '0;
            sp_r = wa;
        end
        sp_res = is_rem ? sp_r : sp_q;
        if (is_w) sp_res = sext32(sp_res);
    end

    // Split path: core divided a>>1, so fold the dropped LSB back in with one restoring step.
    logic [63:0] fx_r2, fx_q2, fx_q, fx_r, fx_res;
    always_comb begin
        fx_r2 = {rem_q[62:0], req.a[0]};
        fx_q2 = {quo_q[62:0], 1'b0};
        fx_q  = quo_q;
        fx_r  = rem_q;
        if (split) begin
            if (fx_r2 >= req.b) begin
                fx_q = fx_q2 + 64'd1;
                fx_r = fx_r2 - req.b;
            end else begin
                fx_q = fx_q2;
                fx_r = fx_r2;
            end
        end
        fx_res = is_rem ? fx_r : fx_q;
        if (is_w) fx_res = sext32(fx_res);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            req        <= '0;
            split      <= 1'b0;
            seen_low   <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            req_rdy_o  <= 1'b0;
            rsp_vld_o  <= 1'b0;
            rsp_data_o <= '0;
            rsp_tag_o  <= '0;
            rsp_dz_o   <= 1'b0;
            div_vld_o  <= 1'b0;
            div_op1_o  <= '0;
            div_op2_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_rdy_o <= 1'b1;
                    if (!flush_i && req_vld_i && req_rdy_o) begin
                        req.op    <= req_op_i;
                        req.a     <= req_a_i;
                        req.b     <= req_b_i;
                        req.tag   <= req_tag_i;
                        req_rdy_o <= 1'b0;
                        state     <= PREP;
                    end
                end
                PREP: begin
                    if (flush_i) begin
                        state     <= IDLE;
                        req_rdy_o <= 1'b1;
                    end else if (b_zero || ovf || big_b) begin
                        rsp_vld_o  <= 1'b1;
                        rsp_data_o <= sp_res;
                        rsp_tag_o  <= req.tag;
                        rsp_dz_o   <= b_zero;
                        state      <= RESP;
                    end else begin
                        div_vld_o <= 1'b1;
                        div_op1_o <= need_split ? (wa >> 1) : wa;
                        div_op2_o <= wb;
                        split     <= need_split;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (div_ready_i) begin
                        div_vld_o <= 1'b0;
                        seen_low  <= 1'b0;
                        state     <= flush_i ? DRAIN : WAIT;
                    end else if (flush_i) begin
                        div_vld_o <= 1'b0;
                        req_rdy_o <= 1'b1;
                        state     <= IDLE;
                    end
                end
                WAIT: begin
                    if (!div_ready_i) seen_low <= 1'b1;
                    if (flush_i) begin
                        state <= DRAIN;
                    end else if (seen_low && div_ready_i) begin
                        quo_q <= div_quo_i;
                        rem_q <= div_rem_i;
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (flush_i) begin
                        seen_low <= 1'b1;
                        state    <= DRAIN;
                    end else begin
                        rsp_vld_o  <= 1'b1;
                        rsp_data_o <= fx_res;
                        rsp_tag_o  <= req.tag;
                        rsp_dz_o   <= 1'b0;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (flush_i || rsp_rdy_i) begin
                        rsp_vld_o <= 1'b0;
                        req_rdy_o <= 1'b1;
                        state     <= IDLE;
                    end
                end
                DRAIN: begin
                    if (!div_ready_i) seen_low <= 1'b1;
                    if (seen_low && div_ready_i) begin
                        req_rdy_o <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_rdy_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_div_seq.sv
// Bench for rv_div_seq: behavioural signed-divider core model plus a RISC-V M-extension
// reference computed directly from the instruction definitions.
module tb_rv_div_seq;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rstn;
    logic             flush_i;
    logic             req_vld_i;
    logic             req_rdy_o;
    logic [2:0]       req_op_i;
    logic [63:0]      req_a_i;
    logic [63:0]      req_b_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             rsp_vld_o;
    logic             rsp_rdy_i;
    logic [63:0]      rsp_data_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic             rsp_dz_o;
    logic             div_vld_o;
    logic [63:0]      div_op1_o;
    logic [63:0]      div_op2_o;
    logic [63:0]      div_quo_i;
    logic [63:0]      div_rem_i;
    logic             div_ready_i;

    always #5 clk = ~clk;

    rv_div_seq #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn), .flush_i(flush_i),
        .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_op_i(req_op_i),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tag_i(req_tag_i),
        .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i), .rsp_data_o(rsp_data_o),
        .rsp_tag_o(rsp_tag_o), .rsp_dz_o(rsp_dz_o),
        .div_vld_o(div_vld_o), .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
        .div_quo_i(div_quo_i), .div_rem_i(div_rem_i), .div_ready_i(div_ready_i)
    );

    // Core model: ready high when idle; accepts on vld&ready, drops ready for core_lat cycles.
    int core_lat = 3;
    int c_cnt;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_ready_i <= 1'b1;
            c_cnt       <= 0;
            div_quo_i   <= '0;
            div_rem_i   <= '0;
        end else if (!div_ready_i) begin
            if (c_cnt <= 1) div_ready_i <= 1'b1;
            else            c_cnt <= c_cnt - 1;
        end else if (div_vld_o) begin
            div_ready_i <= 1'b0;
            c_cnt       <= core_lat;
            if (div_op2_o != 0) begin
                div_quo_i <= $signed(div_op1_o) / $signed(div_op2_o);
                div_rem_i <= $signed(div_op1_o) % $signed(div_op2_o);
            end else begin
                div_quo_i <= '1;
                div_rem_i <= div_op1_o;
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [63:0] ref_div(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, q32, r32, s32;
        logic [63:0] q, r;
        a32 = a[31:0];
        b32 = b[31:0];
        if (op[2]) begin
            if (b32 == 0) begin q32 = '1; r32 = a32; end
            else if (op[0]) begin q32 = a32 / b32; r32 = a32 % b32; end
            else if (a32 == 32'h8000_0000 && b32 == '1) begin q32 = a32; r32 = 0; end
            else begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
            s32 = op[1] ? r32 : q32;
            return {{32{s32[31]}}, s32};
        end
        if (b == 0) begin q = '1; r = a; end
        else if (op[0]) begin q = a / b; r = a % b; end
        else if (a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = 0; end
        else begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
        return op[1] ? r : q;
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return {32'h0, 32'h8000_0000};
            4: return 64'($urandom_range(0, 20));
            5: return {32'h0, $urandom()};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Results of the last run_op
    logic [63:0]      got_data;
    logic [TAG_W-1:0] got_tag;
    logic             got_dz, got_dv, got_rdy_bad, got_to, got_hold_bad, got_after_vld, got_after_rdy;
    int               got_lat;

    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [TAG_W-1:0] tag, input int hold);
        int n = 0;
        got_to = 0; got_dv = 0; got_rdy_bad = 0; got_hold_bad = 0;
        while (!req_rdy_o && n < 100) begin @(negedge clk); n++; end
        if (!req_rdy_o) begin got_to = 1; return; end
        req_vld_i = 1; req_op_i = op; req_a_i = a; req_b_i = b; req_tag_i = tag;
        @(negedge clk);
        req_vld_i = 0;
        got_lat = 1;
        while (!rsp_vld_o && got_lat < 300) begin
            if (div_vld_o) got_dv = 1;
            if (req_rdy_o) got_rdy_bad = 1;
            @(negedge clk);
            got_lat++;
        end
        if (!rsp_vld_o) begin got_to = 1; return; end
        if (div_vld_o) got_dv = 1;
        if (req_rdy_o) got_rdy_bad = 1;
        got_data = rsp_data_o; got_tag = rsp_tag_o; got_dz = rsp_dz_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_vld_o !== 1'b1 || rsp_data_o !== got_data || rsp_tag_o !== got_tag ||
                rsp_dz_o !== got_dz || req_rdy_o !== 1'b0) got_hold_bad = 1;
        end
        rsp_rdy_i = 1;
        @(negedge clk);
        rsp_rdy_i = 0;
        got_after_vld = rsp_vld_o;
        got_after_rdy = req_rdy_o;
    endtask

    task automatic test_reset();
        rstn = 0; flush_i = 0; req_vld_i = 0; req_op_i = 0; req_a_i = 0; req_b_i = 0;
        req_tag_i = 0; rsp_rdy_i = 0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({req_rdy_o, rsp_vld_o, rsp_data_o, rsp_tag_o, rsp_dz_o, div_vld_o, div_op1_o, div_op2_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got rdy=%b vld=%b data=%h tag=%h dz=%b dv=%b op1=%h op2=%h exp all zero",
                     req_rdy_o, rsp_vld_o, rsp_data_o, rsp_tag_o, rsp_dz_o, div_vld_o, div_op1_o, div_op2_o);
        end
        rstn = 1;
        n_vec++;
        if (req_rdy_o !== 1'b0) begin n_err++; $display("FAIL reset_rdy_before_edge got %b exp 0", req_rdy_o); end
        @(negedge clk);
        n_vec++;
        if (req_rdy_o !== 1'b1) begin n_err++; $display("FAIL reset_rdy_after_edge got %b exp 1", req_rdy_o); end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a, b, exp;
        logic        dz, no_core;
    } dir_t;

    task automatic test_directed();
        dir_t t[10];
        t[0] = '{3'b000, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0};
        t[1] = '{3'b010, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0};
        t[2] = '{3'b001, 64'h8000_0000_0000_0001, 64'd3, 64'h2AAA_AAAA_AAAA_AAAB, 0, 0};
        t[3] = '{3'b011, 64'h8000_0000_0000_0001, 64'd3, 64'd0, 0, 0};
        t[4] = '{3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd1, 0, 1};
        t[5] = '{3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1};
        t[6] = '{3'b001, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1};
        t[7] = '{3'b110, 64'h8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1, 1};
        t[8] = '{3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0, 1};
        t[9] = '{3'b010, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 1};
        core_lat = 4;
        for (int i = 0; i < 10; i++) begin
            run_op(t[i].op, t[i].a, t[i].b, TAG_W'(i + 3), 0);
            n_vec++;
            if (got_to || got_data !== t[i].exp || got_tag !== TAG_W'(i + 3) || got_dz !== t[i].dz) begin
                n_err++;
                $display("FAIL directed_%0d got data=%h tag=%0d dz=%b to=%b exp data=%h tag=%0d dz=%b",
                         i, got_data, got_tag, got_dz, got_to, t[i].exp, i + 3, t[i].dz);
            end
            // Special cases: no core traffic and response two cycles after acceptance.
            // Core path: PREP + ISSUE + core_lat busy cycles + result cycle + FIX, response next.
            n_vec++;
            if (t[i].no_core ? (got_dv !== 1'b0 || got_lat != 2) : (got_dv !== 1'b1 || got_lat != core_lat + 5)) begin
                n_err++;
                $display("FAIL directed_%0d_path got div_vld_seen=%b lat=%0d exp div_vld_seen=%b lat=%0d",
                         i, got_dv, got_lat, !t[i].no_core, t[i].no_core ? 2 : core_lat + 5);
            end
        end
    endtask

    task automatic test_hold();
        core_lat = 2;
        run_op(3'b000, 64'd1000, 64'd7, TAG_W'(9), 5);
        n_vec++;
        if (got_to || got_hold_bad || got_rdy_bad || got_data !== 64'd142) begin
            n_err++;
            $display("FAIL hold_stable got to=%b unstable=%b rdy_early=%b data=%h exp 0 0 0 %h",
                     got_to, got_hold_bad, got_rdy_bad, got_data, 64'd142);
        end
        n_vec++;
        if (got_after_vld !== 1'b0 || got_after_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL hold_release got vld=%b rdy=%b exp vld=0 rdy=1", got_after_vld, got_after_rdy);
        end
    endtask

    task automatic test_flush_accept();
        bit bad = 0;
        int n = 0;
        while (!req_rdy_o && n < 100) begin @(negedge clk); n++; end
        req_vld_i = 1; flush_i = 1; req_op_i = 3'b000; req_a_i = 64'd50; req_b_i = 64'd5; req_tag_i = 1;
        @(negedge clk);
        req_vld_i = 0; flush_i = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_vld_o !== 1'b0 || div_vld_o !== 1'b0 || req_rdy_o !== 1'b1) bad = 1;
            @(negedge clk);
        end
        n_vec++;
        if (bad) begin n_err++; $display("FAIL flush_at_accept got activity after dropped request exp none"); end
    endtask

    task automatic test_flush_wait();
        int n = 0;
        bit bad = 0;
        logic [63:0] ea, eb;
        core_lat = 8;
        while (!req_rdy_o && n < 100) begin @(negedge clk); n++; end
        req_vld_i = 1; req_op_i = 3'b000; req_a_i = 64'd100; req_b_i = 64'd7; req_tag_i = 2;
        @(negedge clk);
        req_vld_i = 0;
        n = 0;
        while (!div_vld_o && n < 20) begin @(negedge clk); n++; end
        while (div_vld_o && n < 40) begin @(negedge clk); n++; end
        n_vec++;
        if (n >= 40 || div_ready_i !== 1'b0) begin
            n_err++;
            $display("FAIL flush_wait_setup got cycles=%0d core_ready=%b exp core busy", n, div_ready_i);
        end
        flush_i = 1;
        @(negedge clk);
        flush_i = 0;
        n = 0;
        while (!div_ready_i && n < 50) begin
            if (rsp_vld_o !== 1'b0 || req_rdy_o !== 1'b0) bad = 1;
            @(negedge clk);
            n++;
        end
        if (rsp_vld_o !== 1'b0 || req_rdy_o !== 1'b0) bad = 1;
        n_vec++;
        if (bad || n >= 50) begin
            n_err++;
            $display("FAIL flush_wait_drain got early rsp/rdy=%b timeout=%b exp 0 0", bad, n >= 50);
        end
        @(negedge clk);
        n_vec++;
        if (req_rdy_o !== 1'b1 || rsp_vld_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_wait_rdy got rdy=%b vld=%b exp rdy=1 vld=0", req_rdy_o, rsp_vld_o);
        end
        core_lat = 3;
        ea = -64'sd1000001; eb = 64'd13;
        run_op(3'b010, ea, eb, TAG_W'(17), 0);
        n_vec++;
        if (got_to || got_data !== ref_div(3'b010, ea, eb) || got_tag !== TAG_W'(17)) begin
            n_err++;
            $display("FAIL flush_wait_next got data=%h tag=%0d to=%b exp data=%h tag=17",
                     got_data, got_tag, got_to, ref_div(3'b010, ea, eb));
        end
    endtask

    task automatic test_random();
        logic [2:0]       op;
        logic [63:0]      a, b, exp;
        logic [TAG_W-1:0] tag;
        logic             edz;
        for (int i = 0; i < 200; i++) begin
            op = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            tag = TAG_W'($urandom());
            core_lat = $urandom_range(1, 6);
            exp = ref_div(op, a, b);
            edz = op[2] ? (b[31:0] == 0) : (b == 0);
            run_op(op, a, b, tag, $urandom_range(0, 2));
            n_vec++;
            if (got_to || got_data !== exp || got_tag !== tag || got_dz !== edz ||
                got_rdy_bad || got_hold_bad) begin
                n_err++;
                $display("FAIL random_%0d op=%b a=%h b=%h got data=%h tag=%0d dz=%b to=%b rdy_early=%b unstable=%b exp data=%h tag=%0d dz=%b",
                         i, op, a, b, got_data, got_tag, got_dz, got_to, got_rdy_bad, got_hold_bad, exp, tag, edz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_flush_accept();
        test_flush_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
